// File: rtl/axis_pkt_pkg.sv
// axis_pkt_pkg: shared widths, metadata record and FSM state encodings for the packet FIFO
package axis_pkt_pkg;
    localparam int DAT_W     = 256;
    localparam int STRB_W    = 32;
    localparam int LEN_W     = 16;
    localparam int PT_W      = 8;
    // end_ptr is stored zero-extended to a fixed width so the record is independent of DEPTH
    localparam int PTR_MAX_W = 16;
    localparam logic [0:0] FILL    = 1'b0;
    localparam logic [0:0] DISCARD = 1'b1;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SEND    = 1'b1;
    typedef struct packed {
        logic [LEN_W-1:0]     len;
        logic [PT_W-1:0]      spt;
        logic [PT_W-1:0]      dpt;
        logic                 err;
        logic [PTR_MAX_W-1:0] end_ptr;
    } meta_t;
endpackage

// File: rtl/axis_pkt_meta_fifo.sv
// axis_pkt_meta_fifo: synchronous FIFO of per-packet metadata records
//   clk, rst_n      clock, async active-low reset
//   push, din       write one record (caller guarantees !full)
//   pop             drop the head record (caller guarantees !empty)
//   head, next      oldest record and the one behind it
//   full, empty     occupancy flags from registered pointers
//   count           number of records held
module axis_pkt_meta_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  meta_t                  din,
    input  logic                   pop,
    output meta_t                  head,
    output meta_t                  next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    meta_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign next  = mem[AW'(rd_ptr[AW-1:0] + 1'b1)];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI4-Stream packet buffer with per-packet sideband replay
//   ACLK, ARESETN            clock, async active-low reset
//   S_AXIS_DAT_*             ingress beats (TDATA/TSTRB/TLAST/TVALID -> TREADY)
//   S_AXIS_LEN/SPT/DPT       sideband sampled on the accepted TLAST beat
//   S_AXIS_ERR_TVALID        error flag OR-ed over the packet
//   M_AXIS_DAT_*             egress beats, only whole stored packets
//   M_AXIS_LEN/SPT/DPT/ERR   sideband held for every beat of the outgoing packet
//   PKT_COUNT, DROP_COUNT    stored packets, saturating oversize/error drops
//   AXIS_PKT_FIFO_DROP_ERR_EN  when defined, errored packets are dropped instead of forwarded
module axis_pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [255:0]              S_AXIS_DAT_TDATA,
    input  logic                      S_AXIS_DAT_TVALID,
    input  logic [31:0]               S_AXIS_DAT_TSTRB,
    input  logic                      S_AXIS_DAT_TLAST,
    output logic                      S_AXIS_DAT_TREADY,
    input  logic [15:0]               S_AXIS_LEN_TDATA,
    input  logic [7:0]                S_AXIS_SPT_TDATA,
    input  logic [7:0]                S_AXIS_DPT_TDATA,
    input  logic                      S_AXIS_ERR_TVALID,
    output logic [255:0]              M_AXIS_DAT_TDATA,
    output logic                      M_AXIS_DAT_TVALID,
    output logic [31:0]               M_AXIS_DAT_TSTRB,
    output logic                      M_AXIS_DAT_TLAST,
    input  logic                      M_AXIS_DAT_TREADY,
    output logic [15:0]               M_AXIS_LEN_TDATA,
    output logic [7:0]                M_AXIS_SPT_TDATA,
    output logic [7:0]                M_AXIS_DPT_TDATA,
    output logic                      M_AXIS_ERR_TVALID,
    output logic [$clog2(MAX_PKTS):0] PKT_COUNT,
    output logic [15:0]               DROP_COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;
    logic [DAT_W+STRB_W-1:0] ram [DEPTH];
    logic [DAT_W+STRB_W-1:0] rd_word;
    logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, wr_inc, rd_inc;
    logic in_st, eg_st, err_acc;
    logic s_acc, s_fill, send, over, err_cur, err_drop, err_fwd, drop_evt, m_last;
    logic meta_push, meta_pop, meta_full, meta_empty;
    logic [CW-1:0] meta_cnt;
    meta_t meta_in, meta_head, meta_next, cur;

    assign wr_inc  = wr_ptr + 1'b1;
    assign rd_inc  = rd_ptr + 1'b1;
    assign s_fill  = in_st == FILL;
    assign send    = eg_st == SEND;
    assign S_AXIS_DAT_TREADY = !s_fill || (wr_ptr - rd_ptr != PW'(DEPTH) && !meta_full);
    assign s_acc   = S_AXIS_DAT_TVALID && S_AXIS_DAT_TREADY;
    assign err_cur = err_acc | S_AXIS_ERR_TVALID;
`ifdef AXIS_PKT_FIFO_DROP_ERR_EN
    assign err_drop = err_cur;
    assign err_fwd  = 1'b0;
`else
    assign err_drop = 1'b0;
    assign err_fwd  = err_cur;
`endif
    // a non-last beat that fills the whole buffer can never become a complete packet
    assign over      = s_fill && s_acc && !S_AXIS_DAT_TLAST && (wr_inc - cmt_ptr == PW'(DEPTH));
    assign meta_push = s_fill && s_acc && S_AXIS_DAT_TLAST && !err_drop;
    assign drop_evt  = over || (s_fill && s_acc && S_AXIS_DAT_TLAST && err_drop);
    assign meta_in   = '{S_AXIS_LEN_TDATA, S_AXIS_SPT_TDATA, S_AXIS_DPT_TDATA, err_fwd, PTR_MAX_W'(wr_inc)};

    always_ff @(posedge ACLK) begin
        if (s_fill && s_acc) ram[wr_ptr[AW-1:0]] <= {S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            err_acc    <= 1'b0;
            in_st      <= FILL;
            DROP_COUNT <= '0;
        end else begin
            if (drop_evt && DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 1'b1;
            if (s_acc && !s_fill) begin
                if (S_AXIS_DAT_TLAST) in_st <= FILL;
            end else if (s_acc) begin
                if (S_AXIS_DAT_TLAST) begin
                    err_acc <= 1'b0;
                    wr_ptr  <= err_drop ? cmt_ptr : wr_inc;
                    cmt_ptr <= err_drop ? cmt_ptr : wr_inc;
                end else if (over) begin
                    wr_ptr  <= cmt_ptr;
                    err_acc <= 1'b0;
                    in_st   <= DISCARD;
                end else begin
                    wr_ptr  <= wr_inc;
                    err_acc <= err_cur;
                end
            end
        end
    end

    axis_pkt_meta_fifo #(.DEPTH(MAX_PKTS)) u_meta (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (meta_push),
        .din   (meta_in),
        .pop   (meta_pop),
        .head  (meta_head),
        .next  (meta_next),
        .full  (meta_full),
        .empty (meta_empty),
        .count (meta_cnt)
    );

    assign m_last   = send && (PTR_MAX_W'(rd_inc) == cur.end_ptr);
    assign meta_pop = send && M_AXIS_DAT_TREADY && m_last;

    // the record behind the head lets a new packet start on the beat after TLAST
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_ptr <= '0;
            eg_st  <= IDLE;
            cur    <= '0;
        end else if (!send) begin
            if (!meta_empty) begin
                cur   <= meta_head;
                eg_st <= SEND;
            end
        end else if (M_AXIS_DAT_TREADY) begin
            rd_ptr <= rd_inc;
            if (m_last) begin
                if (meta_cnt > CW'(1)) cur <= meta_next;
                else eg_st <= IDLE;
            end
        end
    end

    assign rd_word           = ram[rd_ptr[AW-1:0]];
    assign M_AXIS_DAT_TVALID = send;
    assign M_AXIS_DAT_TDATA  = send ? rd_word[DAT_W+STRB_W-1:STRB_W] : '0;
    assign M_AXIS_DAT_TSTRB  = send ? rd_word[STRB_W-1:0] : '0;
    assign M_AXIS_DAT_TLAST  = m_last;
    assign M_AXIS_LEN_TDATA  = cur.len;
    assign M_AXIS_SPT_TDATA  = cur.spt;
    assign M_AXIS_DPT_TDATA  = cur.dpt;
    assign M_AXIS_ERR_TVALID = cur.err;
    assign PKT_COUNT         = meta_cnt;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: directed self-checking bench for the store-and-forward packet FIFO
module tb_axis_pkt_fifo;
    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [255:0] S_AXIS_DAT_TDATA;
    logic         S_AXIS_DAT_TVALID;
    logic [31:0]  S_AXIS_DAT_TSTRB;
    logic         S_AXIS_DAT_TLAST;
    logic         S_AXIS_DAT_TREADY;
    logic [15:0]  S_AXIS_LEN_TDATA;
    logic [7:0]   S_AXIS_SPT_TDATA;
    logic [7:0]   S_AXIS_DPT_TDATA;
    logic         S_AXIS_ERR_TVALID;
    logic [255:0] M_AXIS_DAT_TDATA;
    logic         M_AXIS_DAT_TVALID;
    logic [31:0]  M_AXIS_DAT_TSTRB;
    logic         M_AXIS_DAT_TLAST;
    logic         M_AXIS_DAT_TREADY;
    logic [15:0]  M_AXIS_LEN_TDATA;
    logic [7:0]   M_AXIS_SPT_TDATA;
    logic [7:0]   M_AXIS_DPT_TDATA;
    logic         M_AXIS_ERR_TVALID;
    logic [3:0]   PKT_COUNT;
    logic [15:0]  DROP_COUNT;

    always #5 ACLK = ~ACLK;

    axis_pkt_fifo #(.DEPTH(64), .MAX_PKTS(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_DAT_TDATA(S_AXIS_DAT_TDATA), .S_AXIS_DAT_TVALID(S_AXIS_DAT_TVALID),
        .S_AXIS_DAT_TSTRB(S_AXIS_DAT_TSTRB), .S_AXIS_DAT_TLAST(S_AXIS_DAT_TLAST),
        .S_AXIS_DAT_TREADY(S_AXIS_DAT_TREADY), .S_AXIS_LEN_TDATA(S_AXIS_LEN_TDATA),
        .S_AXIS_SPT_TDATA(S_AXIS_SPT_TDATA), .S_AXIS_DPT_TDATA(S_AXIS_DPT_TDATA),
        .S_AXIS_ERR_TVALID(S_AXIS_ERR_TVALID),
        .M_AXIS_DAT_TDATA(M_AXIS_DAT_TDATA), .M_AXIS_DAT_TVALID(M_AXIS_DAT_TVALID),
        .M_AXIS_DAT_TSTRB(M_AXIS_DAT_TSTRB), .M_AXIS_DAT_TLAST(M_AXIS_DAT_TLAST),
        .M_AXIS_DAT_TREADY(M_AXIS_DAT_TREADY), .M_AXIS_LEN_TDATA(M_AXIS_LEN_TDATA),
        .M_AXIS_SPT_TDATA(M_AXIS_SPT_TDATA), .M_AXIS_DPT_TDATA(M_AXIS_DPT_TDATA),
        .M_AXIS_ERR_TVALID(M_AXIS_ERR_TVALID),
        .PKT_COUNT(PKT_COUNT), .DROP_COUNT(DROP_COUNT)
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic         l;
        logic [32:0]  sb;
        int           c;
    } beat_t;

    beat_t rxq[$];
    beat_t pb;
    int errs = 0;
    int checks = 0;
    int ncyc = 0;
    int s_last_cyc = 0;
    int m_rise_cyc = 0;
    int pk_max = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_dat(input int pid, input int b);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = {8'(i), 8'h5A, 8'(pid), 8'(b)};
        return d;
    endfunction

    function automatic logic [31:0] mk_stb(input int pid, input int b);
        return {8'(pid), 8'(b), ~8'(pid), ~8'(b)};
    endfunction

    // observes both sides on the falling edge, away from the active edge
    always @(negedge ACLK) begin
        beat_t cur;
        ncyc++;
        cur.d  = M_AXIS_DAT_TDATA;
        cur.s  = M_AXIS_DAT_TSTRB;
        cur.l  = M_AXIS_DAT_TLAST;
        cur.sb = {M_AXIS_ERR_TVALID, M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA};
        cur.c  = ncyc;
        if (S_AXIS_DAT_TVALID && S_AXIS_DAT_TREADY && S_AXIS_DAT_TLAST) s_last_cyc = ncyc;
        if (M_AXIS_DAT_TVALID && !pv) m_rise_cyc = ncyc;
        if (ARESETN && pv && !pr) begin
            chk("hold_valid", 64'(M_AXIS_DAT_TVALID), 64'd1);
            chk("hold_data", {cur.d[255:224], cur.d[31:0]}, {pb.d[255:224], pb.d[31:0]});
            chk("hold_side", {cur.s, 30'd0, cur.l, cur.sb[32]}, {pb.s, 30'd0, pb.l, pb.sb[32]});
        end
        if (M_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY) rxq.push_back(cur);
        if (int'(PKT_COUNT) > pk_max) pk_max = int'(PKT_COUNT);
        pv = M_AXIS_DAT_TVALID;
        pr = M_AXIS_DAT_TREADY;
        pb = cur;
    end

    task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic last,
                             input logic err, input logic [15:0] len, input logic [7:0] spt,
                             input logic [7:0] dpt);
        int n = 0;
        S_AXIS_DAT_TDATA  = d;
        S_AXIS_DAT_TSTRB  = s;
        S_AXIS_DAT_TLAST  = last;
        S_AXIS_ERR_TVALID = err;
        S_AXIS_LEN_TDATA  = len;
        S_AXIS_SPT_TDATA  = spt;
        S_AXIS_DPT_TDATA  = dpt;
        S_AXIS_DAT_TVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXIS_DAT_TREADY && n < 1000) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 1000) chk("s_ready_timeout", 64'(S_AXIS_DAT_TREADY), 64'd1);
        @(posedge ACLK);
        #1;
        S_AXIS_DAT_TVALID = 1'b0;
        S_AXIS_DAT_TLAST  = 1'b0;
        S_AXIS_ERR_TVALID = 1'b0;
    endtask

    // sideband carries junk on non-last beats so that only the TLAST sample can pass
    task automatic send_pkt(input int pid, input int nb, input logic [15:0] len,
                            input logic [7:0] spt, input logic [7:0] dpt, input int eb);
        for (int b = 0; b < nb; b++) begin
            logic lst;
            lst = (b == nb - 1);
            send_beat(mk_dat(pid, b), mk_stb(pid, b), lst, b == eb,
                      lst ? len : 16'hDEAD, lst ? spt : 8'hEE, lst ? dpt : 8'hEE);
        end
    endtask

    task automatic exp_pkt(input int pid, input int nb, input logic [15:0] len,
                           input logic [7:0] spt, input logic [7:0] dpt, input logic err);
        for (int b = 0; b < nb; b++) begin
            beat_t x;
            logic [255:0] e;
            if (rxq.size() == 0) begin
                chk("rx_short", 64'(rxq.size()), 64'(nb - b));
                return;
            end
            x = rxq.pop_front();
            e = mk_dat(pid, b);
            chk("data", {x.d[255:224], x.d[31:0]}, {e[255:224], e[31:0]});
            chk("strb", 64'(x.s), 64'(mk_stb(pid, b)));
            chk("last", 64'(x.l), 64'(b == nb - 1));
            chk("sideband", 64'(x.sb), 64'({err, len, spt, dpt}));
        end
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (rxq.size() < n && t < 1000) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        repeat (4) @(posedge ACLK);
        #1;
        chk("beat_count", 64'(rxq.size()), 64'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t;
        S_AXIS_DAT_TDATA  = '0;
        S_AXIS_DAT_TVALID = 1'b0;
        S_AXIS_DAT_TSTRB  = '0;
        S_AXIS_DAT_TLAST  = 1'b0;
        S_AXIS_LEN_TDATA  = '0;
        S_AXIS_SPT_TDATA  = '0;
        S_AXIS_DPT_TDATA  = '0;
        S_AXIS_ERR_TVALID = 1'b0;
        M_AXIS_DAT_TREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_valid", 64'(M_AXIS_DAT_TVALID), 64'd0);
        chk("rst_data", {M_AXIS_DAT_TDATA[255:224], M_AXIS_DAT_TSTRB}, 64'd0);
        chk("rst_side", 64'({M_AXIS_DAT_TLAST, M_AXIS_ERR_TVALID, M_AXIS_LEN_TDATA,
                             M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA}), 64'd0);
        chk("rst_counts", 64'({PKT_COUNT, DROP_COUNT}), 64'd0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rdy_after_rst", 64'(S_AXIS_DAT_TREADY), 64'd1);

        // single 4-beat packet and first-beat latency
        @(posedge ACLK);
        #1;
        M_AXIS_DAT_TREADY = 1'b1;
        send_pkt(1, 4, 16'd128, 8'd3, 8'd5, -1);
        wait_beats(4);
        chk("latency", 64'((m_rise_cyc > s_last_cyc) && (m_rise_cyc - s_last_cyc <= 2)), 64'd1);
        exp_pkt(1, 4, 16'd128, 8'd3, 8'd5, 1'b0);

        // three back-to-back 2-beat packets must leave as one unbroken run
        pk_max = 0;
        for (int p = 2; p <= 4; p++) send_pkt(p, 2, 16'(p * 64), 8'(p), 8'(p + 16), -1);
        wait_beats(6);
        for (int i = 1; i < 6 && i < rxq.size(); i++) chk("contiguous", 64'(rxq[i].c - rxq[i-1].c), 64'd1);
        chk("pk_peak", 64'(pk_max >= 1 && pk_max <= 3), 64'd1);
        chk("pk_end", 64'(PKT_COUNT), 64'd0);
        for (int p = 2; p <= 4; p++) exp_pkt(p, 2, 16'(p * 64), 8'(p), 8'(p + 16), 1'b0);

        // fill the whole buffer with egress stalled, then drain
        M_AXIS_DAT_TREADY = 1'b0;
        for (int p = 10; p <= 13; p++) send_pkt(p, 16, 16'd512, 8'(p), 8'(p + 1), -1);
        repeat (2) @(posedge ACLK);
        #1;
        chk("full_ready", 64'(S_AXIS_DAT_TREADY), 64'd0);
        chk("full_pkts", 64'(PKT_COUNT), 64'd4);
        chk("full_valid", 64'(M_AXIS_DAT_TVALID), 64'd1);
        fork
            send_pkt(14, 2, 16'd64, 8'd1, 8'd2, -1);
            begin
                repeat (3) @(posedge ACLK);
                #1;
                M_AXIS_DAT_TREADY = 1'b1;
            end
        join
        wait_beats(66);
        for (int p = 10; p <= 13; p++) exp_pkt(p, 16, 16'd512, 8'(p), 8'(p + 1), 1'b0);
        exp_pkt(14, 2, 16'd64, 8'd1, 8'd2, 1'b0);

        // oversize packet is discarded, the next one passes
        send_pkt(40, 70, 16'd2240, 8'd7, 8'd7, -1);
        repeat (8) @(posedge ACLK);
        #1;
        chk("drop_no_out", 64'(rxq.size()), 64'd0);
        chk("drop_count", 64'(DROP_COUNT), 64'd1);
        chk("drop_pkts", 64'(PKT_COUNT), 64'd0);
        send_pkt(41, 2, 16'd64, 8'd8, 8'd9, -1);
        wait_beats(2);
        exp_pkt(41, 2, 16'd64, 8'd8, 8'd9, 1'b0);

        // error on the middle beat of a 3-beat packet
        send_pkt(20, 3, 16'd96, 8'd1, 8'd2, 1);
`ifdef AXIS_PKT_FIFO_DROP_ERR_EN
        repeat (8) @(posedge ACLK);
        #1;
        chk("err_no_out", 64'(rxq.size()), 64'd0);
        chk("err_drop_count", 64'(DROP_COUNT), 64'd2);
`else
        wait_beats(3);
        exp_pkt(20, 3, 16'd96, 8'd1, 8'd2, 1'b1);
        chk("err_drop_count", 64'(DROP_COUNT), 64'd1);
`endif
        send_pkt(21, 2, 16'd64, 8'd3, 8'd4, -1);
        wait_beats(2);
        exp_pkt(21, 2, 16'd64, 8'd3, 8'd4, 1'b0);

        // reset while the third beat of a packet is on the egress side
        send_pkt(30, 6, 16'd192, 8'd5, 8'd6, -1);
        t = 0;
        while (rxq.size() < 2 && t < 1000) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        chk("pre_rst_beats", 64'(rxq.size()), 64'd2);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_valid", 64'(M_AXIS_DAT_TVALID), 64'd0);
        chk("mid_rst_data", {M_AXIS_DAT_TDATA[255:224], M_AXIS_DAT_TSTRB}, 64'd0);
        chk("mid_rst_side", 64'({M_AXIS_DAT_TLAST, M_AXIS_ERR_TVALID, M_AXIS_LEN_TDATA,
                                 M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA}), 64'd0);
        chk("mid_rst_counts", 64'({PKT_COUNT, DROP_COUNT}), 64'd0);
        rxq.delete();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        send_pkt(31, 2, 16'd64, 8'd9, 8'd10, -1);
        wait_beats(2);
        exp_pkt(31, 2, 16'd64, 8'd9, 8'd10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Store-and-forward AXI4-Stream packet buffer on the OPED egress stream (S side), feeding the loopback/arbiter stage (M side).
- Forwards a packet only after its TLAST beat is stored, so the downstream stage sees gap-free packets.
- Captures the per-packet sideband (LEN, SPT, DPT, ERR) and replays it stably for the whole outgoing packet.
- Drops oversize packets and counts them.

Parameters:
- DEPTH, 64: data buffer depth in 256-bit beats; power of 2, minimum 4.
- MAX_PKTS, 8: metadata FIFO depth, i.e. the maximum number of complete packets held; power of 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
- S_AXIS_DAT_TDATA  in  256  ingress data.
- S_AXIS_DAT_TVALID  in  1  ingress valid.
- S_AXIS_DAT_TSTRB  in  32  ingress byte strobes.
- S_AXIS_DAT_TLAST  in  1  ingress end of packet.
- S_AXIS_DAT_TREADY  out  1  ingress ready.
- S_AXIS_LEN_TDATA  in  16  packet byte length; sampled on the accepted TLAST beat.
- S_AXIS_SPT_TDATA  in  8  source port; sampled on the accepted TLAST beat.
- S_AXIS_DPT_TDATA  in  8  destination port; sampled on the accepted TLAST beat.
- S_AXIS_ERR_TVALID  in  1  error flag; OR-accumulated over all accepted beats of a packet.
- M_AXIS_DAT_TDATA  out  256  egress data.
- M_AXIS_DAT_TVALID  out  1  egress valid.
- M_AXIS_DAT_TSTRB  out  32  egress byte strobes.
- M_AXIS_DAT_TLAST  out  1  egress end of packet.
- M_AXIS_DAT_TREADY  in  1  egress ready.
- M_AXIS_LEN_TDATA  out  16  egress length sideband.
- M_AXIS_SPT_TDATA  out  8  egress source port sideband.
- M_AXIS_DPT_TDATA  out  8  egress destination port sideband.
- M_AXIS_ERR_TVALID  out  1  egress error sideband.
- PKT_COUNT  out  clog2(MAX_PKTS)+1  number of complete packets stored.
- DROP_COUNT  out  16  saturating count of oversize drops.
- Clock and reset (decided): one clock; reset is asynchronous and active-low. ACLK is the single clock; ARESETN is the asynchronous, active-low reset. All state is cleared on ARESETN low; release is synchronous to ACLK.

Behaviour:
- Pointers: wr_ptr (uncommitted write), cmt_ptr (committed end), rd_ptr; each clog2(DEPTH)+1 bits, wrap bit in the MSB.
- Reset: all pointers 0, ingress FSM = FILL, metadata FIFO empty.
  - M_AXIS_DAT_TVALID=0; all M data/sideband outputs 0.
  - PKT_COUNT=0, DROP_COUNT=0.
  - A partially received or partially sent packet is lost; nothing resumes after reset.
- Ingress FSM, state FILL:
  - S_TREADY = !(wr_ptr-rd_ptr==DEPTH) && !meta_full.
  - An accepted beat writes {TDATA,TSTRB} at wr_ptr, then wr_ptr++.
  - Accepted TLAST beat: push meta {LEN,SPT,DPT,err_acc|ERR,end_ptr=wr_ptr+1}; cmt_ptr<=wr_ptr+1; err_acc<=0.
  - Accepted non-TLAST beat that brings wr_ptr-cmt_ptr to DEPTH (oversize packet): wr_ptr<=cmt_ptr; DROP_COUNT++ (saturating at 16'hFFFF); go to DISCARD.
- Ingress FSM, state DISCARD:
  - S_TREADY=1; beats are swallowed and not written.
  - Accepted TLAST: return to FILL; no metadata is pushed.
- Full/empty flags are computed from registered pointers only. Space freed by a read is usable the cycle after. Simultaneous push and pop are both legal in the same cycle.
- Egress FSM, state IDLE: when the metadata FIFO is non-empty, load the sideband registers and go to SEND.
- Egress FSM, state SEND:
  - M_TVALID=1; data comes from RAM[rd_ptr].
  - M_TLAST=(rd_ptr+1==end_ptr).
  - On handshake: rd_ptr++. If TLAST: pop meta; if another packet is ready, go straight to SEND with no bubble; else go to IDLE.
- Egress AXI rules: M outputs are held stable while TVALID && !TREADY. Sideband is constant for every beat of a packet and holds its last value when idle.
- Latency: a TLAST accepted on the S side in cycle N gives M_TVALID no later than cycle N+2. Throughput is 1 beat/cycle sustained on both sides.
- PKT_COUNT = metadata FIFO occupancy; it updates the cycle after a push or pop.

Optional Feature:
- Macro AXIS_PKT_FIFO_DROP_ERR_EN.
- Defined: a packet whose err_acc|ERR is set at TLAST is not committed: wr_ptr<=cmt_ptr, no meta push, DROP_COUNT++. M_AXIS_ERR_TVALID is tied 0.
- Undefined: errored packets are forwarded and M_AXIS_ERR_TVALID carries their accumulated error.

Decomposition:
- Shared package axis_pkt_pkg:
  - Width constants: DAT_W=256, STRB_W=32, LEN_W=16, PT_W=8.
  - Typedef meta_t = {len, spt, dpt, err, end_ptr}.
  - Enums for the ingress states {FILL, DISCARD} and egress states {IDLE, SEND}.
- One sub-module: axis_pkt_meta_fifo, a generic synchronous FIFO of meta_t holding MAX_PKTS entries, with full/empty flags and a count output.
- The data RAM is inferred inside the top level.

Test Plan:
- Single 4-beat packet (LEN=128, SPT=3, DPT=5), M_TREADY=1 -> M_TVALID rises no later than 2 cycles after S TLAST; 4 beats in order; TLAST on beat 4; sideband 128/3/5 on every beat.
- Three back-to-back 2-beat packets, M_TREADY=1 -> 6 contiguous M beats; PKT_COUNT peaks ≤3 and ends at 0.
- DEPTH=64, M_TREADY=0, stream 16-beat packets -> S_TREADY drops after 64 beats. Raising M_TREADY drains all 4 packets intact, then ingress resumes.
- 70-beat packet with DEPTH=64 -> dropped, DROP_COUNT=1, no M output. A following 2-beat packet is forwarded correctly.
- ERR asserted on beat 2 of 3 -> forwarded with M_ERR=1 (macro undefined) / dropped with DROP_COUNT=1 (macro defined).
- ARESETN low during beat 3 of an egress packet -> all M outputs 0 next edge, PKT_COUNT=0. A new packet after reset is forwarded cleanly.
